// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loaderStateT   : loader FSM encoding (CKSUM only reachable with checksum build)
//   HDR_BYTES      : header length in bytes (16-bit word count, LSB first)
//   BYTES_PER_WORD : payload bytes packed into one instruction word
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5,
        CKSUM = 3'd6
    } loaderStateT;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_le_word_packer.sv
// le_word_packer: packs bytes into 32-bit little-endian words.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of byte counter and shift register
//   byteEn     : byteIn is consumed this cycle
//   byteIn     : incoming byte (first byte ends up in word[7:0])
//   word       : packed word, complete while wordValid is high
//   wordValid  : one-cycle pulse the cycle after the 4th byte of a word
//   lastByte   : the next consumed byte completes the current word
module le_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byteEn,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        wordValid,
    output logic        lastByte
);

    logic [1:0] byteCnt;

    assign lastByte = (byteCnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byteCnt   <= 2'd0;
            word      <= 32'd0;
            wordValid <= 1'b0;
        end else begin
            wordValid <= byteEn && lastByte;
            if (clr) begin
                byteCnt <= 2'd0;
                word    <= 32'd0;
            end else if (byteEn) begin
                byteCnt <= byteCnt + 2'd1;
                // Shift right so the first byte of a word lands in the low lane.
                word    <= {byteIn, word[31:8]};
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-stream image into instruction memory and holds the
// pipeline core in reset until the image is complete.
// Stream: N[7:0], N[15:8], then 4*N payload bytes (each word LSB first).
// Optional build macro IMEM_BOOT_LOADER_CKSUM_EN: one trailing byte must equal the
// modulo-256 sum of all payload bytes, otherwise the load ends in ERR.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : pulse that begins a load (IDLE/DONE/ERR only)
//   s_data, s_valid, s_ready  : byte stream handshake
//   imem_we/addr/wdata        : instruction-memory write port, one strobe per word
//   core_rst                  : core reset, released only after a good load
//   busy, done, error         : load status
//   words_loaded              : words written in the current load
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    loaderStateT state;
    logic [7:0]  hdrLo;
    logic [15:0] nWords;
    logic        xfer;
    logic        lastByte;
    logic        isLastWord;
    logic [16:0] lastIdx;
    logic [15:0] hdrWords;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    assign xfer       = s_valid && s_ready;
    assign hdrWords   = {s_data, hdrLo};
    assign lastIdx    = {1'b0, nWords} - 17'd1;
    assign isLastWord = (17'(words_loaded) == lastIdx);

    le_word_packer packer (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state == HDR1) && xfer),
        .byteEn    ((state == DATA) && xfer),
        .byteIn    (s_data),
        .word      (imem_wdata),
        .wordValid (imem_we),
        .lastByte  (lastByte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            core_rst     <= 1'b1;
            imem_addr    <= '0;
            words_loaded <= '0;
            hdrLo        <= 8'd0;
            nWords       <= 16'd0;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
            cksum        <= 8'd0;
`endif
        end else begin
            if (imem_we) begin
                imem_addr    <= imem_addr + ADDR_W'(1);
                words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= HDR0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        hdrLo <= s_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        nWords       <= hdrWords;
                        imem_addr    <= '0;
                        words_loaded <= '0;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
                        cksum        <= 8'd0;
`endif
                        if (hdrWords == 16'd0) begin
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
                            state   <= CKSUM;
`else
                            state   <= DONE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
`endif
                        end else if (17'(hdrWords) > MaxWords) begin
                            state   <= ERR;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
                    if (xfer) begin
                        cksum <= cksum + s_data;
                    end
                    // Last word's write is issued by the packer in the first CKSUM cycle.
                    if (xfer && lastByte && isLastWord) begin
                        state <= CKSUM;
                    end
`else
                    // Stop accepting as soon as the final byte is in; the write follows.
                    if (xfer && lastByte && isLastWord) begin
                        s_ready <= 1'b0;
                    end
                    if (imem_we && isLastWord) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
`endif
                end
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
                CKSUM: begin
                    if (xfer) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == cksum) begin
                            state <= DONE;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (start) begin
                        state    <= HDR0;
                        done     <= 1'b0;
                        core_rst <= 1'b1;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end
                end
                ERR: begin
                    if (start) begin
                        state   <= HDR0;
                        error   <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed images, scoreboard on the write port.
module tb_imem_boot_loader;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int tests = 0;
    int fails = 0;

    logic [AW+31:0] expQ[$];
    logic [7:0]     img[$];

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected write: addr %0h data %0h", imem_addr, imem_wdata);
            end else begin
                check("imem write {addr,data}", 64'({imem_addr, imem_wdata}),
                      64'(expQ.pop_front()));
            end
        end
    end

    task automatic pushWord(input int addr, input logic [31:0] data);
        expQ.push_back({AW'(addr), data});
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit got = 1'b0;
        int t = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!got && t < 50) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
            t++;
        end
        s_valid = 1'b0;
        s_data  = 8'hFF;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL sendByte timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic sendImg(input int gapMax);
        foreach (img[i]) begin
            sendByte(img[i]);
            if (gapMax > 0) begin
                int n = $urandom_range(0, gapMax);
                if (n > 0) begin
                    repeat (n) @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    function automatic logic [7:0] imgSum(input int from);
        logic [7:0] s = 8'd0;
        for (int i = from; i < img.size(); i++) s = s + img[i];
        return s;
    endfunction

    task automatic waitOutcome(input bit expDone);
        int t = 0;
        while (!(done || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("outcome done", 64'(done), 64'(expDone));
        check("outcome error", 64'(error), 64'(!expDone));
        check("outcome core_rst", 64'(core_rst), 64'(!expDone));
    endtask

    initial begin
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'hFF;
        rst     = 1'b0;
        #1 rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset core_rst", 64'(core_rst), 64'd1);
        check("reset s_ready/busy/done/error/we", 64'({s_ready, busy, done, error, imem_we}),
              64'd0);
        check("reset addr/wdata/words", 64'({imem_addr, imem_wdata, words_loaded}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle without start s_ready", 64'(s_ready), 64'd0);

        // Image 1: two words, back-to-back bytes.
        @(posedge clk);
        #1;
        pulseStart();
        check("hdr0 s_ready", 64'(s_ready), 64'd1);
        check("hdr0 busy", 64'(busy), 64'd1);
        pushWord(0, 32'h0000_0013);
        pushWord(1, 32'h0010_0093);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        sendImg(0);
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        sendByte(imgSum(2));
        waitOutcome(1'b1);
`else
        @(negedge clk);
        check("write cycle s_ready", 64'(s_ready), 64'd0);
        check("write cycle core_rst", 64'(core_rst), 64'd1);
        @(negedge clk);
        check("k+1 core_rst still held", 64'(core_rst), 64'd1);
        check("k+1 done low", 64'(done), 64'd0);
        @(negedge clk);
        check("k+2 core_rst released", 64'(core_rst), 64'd0);
        check("k+2 done", 64'(done), 64'd1);
        check("k+2 busy", 64'(busy), 64'd0);
`endif
        check("img1 words_loaded", 64'(words_loaded), 64'd2);
        check("img1 scoreboard drained", 64'(expQ.size()), 64'd0);

        // Image 2: empty header.
        pulseStart();
        check("restart done cleared", 64'(done), 64'd0);
        check("restart core_rst held", 64'(core_rst), 64'd1);
        img = '{8'h00, 8'h00};
        sendImg(0);
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        sendByte(8'h00);
`endif
        waitOutcome(1'b1);
        check("empty words_loaded", 64'(words_loaded), 64'd0);

        // Image 3: oversized header 0x0401.
        pulseStart();
        img = '{8'h01, 8'h04};
        sendImg(0);
        @(negedge clk);
        check("oversize error", 64'(error), 64'd1);
        check("oversize core_rst", 64'(core_rst), 64'd1);
        check("oversize s_ready/busy", 64'({s_ready, busy}), 64'd0);
        pulseStart();
        check("err restart error cleared", 64'(error), 64'd0);
        check("err restart s_ready", 64'(s_ready), 64'd1);

        // Image 4: three words with random gaps and a stray start mid-payload.
        pushWord(0, 32'h1122_3344);
        pushWord(1, 32'hDEAD_BEEF);
        pushWord(2, 32'hCAFE_F00D);
        img = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22};
        sendImg(3);
        pulseStart();
        check("start ignored in DATA busy", 64'(busy), 64'd1);
        img = '{8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        sendImg(3);
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        img = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE,
                8'hCA};
        sendByte(imgSum(0));
`endif
        waitOutcome(1'b1);
        check("img4 words_loaded", 64'(words_loaded), 64'd3);
        check("img4 imem_addr", 64'(imem_addr), 64'd3);
        check("img4 scoreboard drained", 64'(expQ.size()), 64'd0);

        // Image 5: maximum count 0x0400 is accepted; reset lands inside word 1.
        pulseStart();
        img = '{8'h00, 8'h04};
        sendImg(0);
        check("max count accepted error", 64'(error), 64'd0);
        check("max count accepted s_ready", 64'(s_ready), 64'd1);
        pushWord(0, 32'h0403_0201);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        sendImg(0);
        #2 rst = 1'b1;
        #1;
        check("midload rst core_rst", 64'(core_rst), 64'd1);
        check("midload rst flags", 64'({s_ready, busy, done, error, imem_we}), 64'd0);
        check("midload rst addr/wdata/words", 64'({imem_addr, imem_wdata, words_loaded}),
              64'd0);
        check("midload scoreboard drained", 64'(expQ.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-rst idle s_ready", 64'(s_ready), 64'd0);

`ifdef IMEM_BOOT_LOADER_CKSUM_EN
        // Checksum match and mismatch.
        @(posedge clk);
        #1;
        pulseStart();
        pushWord(0, 32'h0000_0013);
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        sendImg(0);
        sendByte(8'h13);
        waitOutcome(1'b1);
        pulseStart();
        pushWord(0, 32'h0000_0013);
        sendImg(0);
        sendByte(8'h14);
        waitOutcome(1'b0);
        check("cksum scoreboard drained", 64'(expQ.size()), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits upstream of the five-stage pipeline top.
- Receives a byte stream over a valid/ready handshake, packs it into 32-bit little-endian instruction words and writes them into instruction memory through its write port.
- Holds the pipeline core in reset until the whole image has been loaded, then releases it.

Parameters:
- ADDR_W, 10, word-address width of instruction memory; must be ≤16. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; everything on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  word being written
- core_rst  out  1  reset to the pipeline core (high = held in reset)
- busy  out  1  load in progress
- done  out  1  image loaded, core released
- error  out  1  load aborted
- words_loaded  out  ADDR_W+1  words written in the current load

Behaviour:
- Reset values (asynchronous):
  - state=IDLE
  - core_rst=1
  - s_ready, imem_we, busy, done, error = 0
  - imem_addr, imem_wdata, words_loaded = 0
- Byte transfer occurs only when s_valid&&s_ready. s_data is ignored otherwise.
- Stream format: HDR_LO byte, HDR_HI byte, giving a 16-bit word count N={HI,LO}. Then 4*N payload bytes, each word least-significant byte first.
- States: IDLE, HDR0, HDR1, DATA, DONE, ERR (CKSUM only with the optional feature).
  - IDLE: s_ready=0, core_rst=1. start -> HDR0.
  - HDR0: s_ready=1, busy=1. On transfer, latch LO -> HDR1.
  - HDR1: s_ready=1, busy=1. On transfer, latch HI.
    - N==0 -> DONE.
    - N>2^ADDR_W -> ERR.
    - Otherwise -> DATA, with word index and words_loaded cleared.
  - DATA: s_ready=1 continuously, with no stall on writes.
    - A 2-bit byte counter shifts bytes into a 32-bit packer.
    - The cycle after the 4th byte of a word is accepted: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=packed word. Word index and words_loaded increment on that edge.
    - Payload bytes keep being accepted during the write cycle.
    - When the write of word N-1 occurs, the next state is DONE; s_ready=0 from that write cycle onward.
  - DONE: done=1, core_rst=0, busy=0, s_ready=0. done and core_rst hold until rst or start. start -> HDR0, with core_rst=1 and done=0 on the next cycle.
  - ERR: error=1, core_rst=1, s_ready=0, busy=0. start -> HDR0 and clears error.
- start is ignored in HDR0, HDR1 and DATA (and CKSUM when the optional feature is compiled in).
- Latency: the last payload byte accepted at edge k gives imem_we high in cycle k+1, and done=1 / core_rst=0 from edge k+2.
- imem_addr wraps never: N is bounded by 2^ADDR_W. The index at the final write is N-1.
- rst mid-load aborts immediately. Outputs return to reset values, and partially written memory contents are left as-is.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CKSUM_EN.
- When defined:
  - After the last payload byte is accepted, the loader enters CKSUM, with s_ready=1, busy=1, and the last word's write still issued in the first CKSUM cycle.
  - It accepts one byte and compares it with the 8-bit modulo-256 sum of all payload bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - For N==0 the expected checksum is 0x00, taken after HDR1.
- When undefined: no CKSUM state and no sum register; behaviour is exactly as above.

Decomposition:
- Package imem_boot_loader_pkg holds:
  - the state encoding (3-bit enum including CKSUM)
  - constants HDR_BYTES=2 and BYTES_PER_WORD=4
- One natural sub-module, le_word_packer: byte counter plus 32-bit shift register.
  - Inputs: clk, rst, clr, byte_en, byte.
  - Outputs: word, word_valid pulse.

Test Plan:
- Reset then start. Stream 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013 and addr1=0x00100093, one imem_we each, words_loaded=2, done=1, core_rst falls 2 cycles after the last byte.
- Header 00 00 -> DONE with no imem_we, core_rst=0.
- Header 01 04 (0x0401 > 1024 at ADDR_W=10) -> ERR, error=1, core_rst=1, s_ready=0. Then start clears error and enters HDR0.
- Random s_valid gaps, N=3 -> same words written in order at addr 0..2, with no byte lost or duplicated.
- Assert rst in the middle of word 1 -> all outputs at reset values the same cycle, state IDLE, core_rst=1.
- With CKSUM_EN: N=1, payload 13 00 00 00, checksum 0x13 -> DONE. Same with checksum 0x14 -> ERR. start pulses during DATA have no effect.
